// File: rtl/controller.sv
// Main control decoder: combinational decode of opcode/funct into a control
// word, registered once so every output lags its inputs by one clock.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Option,
  input  logic [5:0] Function,
  output logic [1:0] Regdst,
  output logic       Branch0,
  output logic       Branch1,
  output logic       MemRead,
  output logic [1:0] MemtoReg,
  output logic [2:0] ALUOp,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       Regwrite,
  output logic [1:0] Sign
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_ORI   = 6'b001101,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADDU = 6'b100001,
    FN_SUBU = 6'b100011
  } funct_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_OR    = 3'b010,
    ALU_PASSB = 3'b011
  } aluop_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } regdst_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wbsrc_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } ext_e;

  typedef struct packed {
    logic [1:0] regdst;
    logic       branch0;
    logic       branch1;
    logic       memread;
    logic [1:0] memtoreg;
    logic [2:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] sign;
  } ctrl_t;

  ctrl_t ctrl_next;
  ctrl_t ctrl_q;

  // An all-zero word is the NOP; every unlisted opcode/funct falls to it.
  always_comb begin
    ctrl_next = '0;
    case (Option)
      OP_RTYPE: begin
        case (Function)
          FN_ADDU, FN_SUBU: begin
            ctrl_next.regdst   = DST_RD;
            ctrl_next.aluop    = (Function == FN_SUBU) ? ALU_SUB : ALU_ADD;
            ctrl_next.regwrite = 1'b1;
            ctrl_next.memtoreg = WB_ALU;
            ctrl_next.sign     = EXT_ZERO;
          end
          default: ctrl_next = '0;
        endcase
      end
      OP_ORI: begin
        ctrl_next.regdst   = DST_RT;
        ctrl_next.aluop    = ALU_OR;
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.regwrite = 1'b1;
        ctrl_next.sign     = EXT_ZERO;
      end
      OP_LW: begin
        ctrl_next.regdst   = DST_RT;
        ctrl_next.aluop    = ALU_ADD;
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.memread  = 1'b1;
        ctrl_next.memtoreg = WB_MEM;
        ctrl_next.regwrite = 1'b1;
        ctrl_next.sign     = EXT_SIGN;
      end
      OP_SW: begin
        ctrl_next.aluop    = ALU_ADD;
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.memwrite = 1'b1;
        ctrl_next.sign     = EXT_SIGN;
      end
      OP_BEQ: begin
        ctrl_next.branch0  = 1'b1;
        ctrl_next.aluop    = ALU_SUB;
        ctrl_next.sign     = EXT_SIGN;
      end
      OP_LUI: begin
        ctrl_next.regdst   = DST_RT;
        ctrl_next.aluop    = ALU_PASSB;
        ctrl_next.alusrc   = 1'b1;
        ctrl_next.sign     = EXT_LUI;
        ctrl_next.regwrite = 1'b1;
      end
      OP_JAL: begin
        ctrl_next.branch1  = 1'b1;
        ctrl_next.regdst   = DST_RA;
        ctrl_next.memtoreg = WB_PC4;
        ctrl_next.regwrite = 1'b1;
      end
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_next;
  end

  assign Regdst   = ctrl_q.regdst;
  assign Branch0  = ctrl_q.branch0;
  assign Branch1  = ctrl_q.branch1;
  assign MemRead  = ctrl_q.memread;
  assign MemtoReg = ctrl_q.memtoreg;
  assign ALUOp    = ctrl_q.aluop;
  assign MemWrite = ctrl_q.memwrite;
  assign ALUSrc   = ctrl_q.alusrc;
  assign Regwrite = ctrl_q.regwrite;
  assign Sign     = ctrl_q.sign;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the control decoder: expected words are queued when an
// instruction is driven and popped one edge later when the register captures it.
module tb_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Option = '0;
  logic [5:0] Function = '0;
  logic [1:0] Regdst;
  logic       Branch0;
  logic       Branch1;
  logic       MemRead;
  logic [1:0] MemtoReg;
  logic [2:0] ALUOp;
  logic       MemWrite;
  logic       ALUSrc;
  logic       Regwrite;
  logic [1:0] Sign;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs;

  // Word layout: Regdst,Branch0,Branch1,MemRead,MemtoReg,ALUOp,MemWrite,ALUSrc,Regwrite,Sign
  localparam logic [14:0] W_NOP  = 15'b00_0_0_0_00_000_0_0_0_00;
  localparam logic [14:0] W_ADDU = 15'b01_0_0_0_00_000_0_0_1_00;
  localparam logic [14:0] W_SUBU = 15'b01_0_0_0_00_001_0_0_1_00;
  localparam logic [14:0] W_ORI  = 15'b00_0_0_0_00_010_0_1_1_00;
  localparam logic [14:0] W_LW   = 15'b00_0_0_1_01_000_0_1_1_01;
  localparam logic [14:0] W_SW   = 15'b00_0_0_0_00_000_1_1_0_01;
  localparam logic [14:0] W_BEQ  = 15'b00_1_0_0_00_001_0_0_0_01;
  localparam logic [14:0] W_LUI  = 15'b00_0_0_0_00_011_0_1_1_10;
  localparam logic [14:0] W_JAL  = 15'b10_0_1_0_10_000_0_0_1_00;

  controller dut (
    .clk      (clk),
    .reset    (reset),
    .Option   (Option),
    .Function (Function),
    .Regdst   (Regdst),
    .Branch0  (Branch0),
    .Branch1  (Branch1),
    .MemRead  (MemRead),
    .MemtoReg (MemtoReg),
    .ALUOp    (ALUOp),
    .MemWrite (MemWrite),
    .ALUSrc   (ALUSrc),
    .Regwrite (Regwrite),
    .Sign     (Sign)
  );

  assign obs = {Regdst, Branch0, Branch1, MemRead, MemtoReg, ALUOp,
                MemWrite, ALUSrc, Regwrite, Sign};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    n_cmp++;
    assert ((MemRead & MemWrite) === 1'b0)
    else begin
      n_err++;
      $error("FAIL mem_excl: observed=%b expected=0 at %0t", MemRead & MemWrite, $time);
    end
    n_cmp++;
    assert ((Branch0 & Branch1) === 1'b0)
    else begin
      n_err++;
      $error("FAIL br_excl: observed=%b expected=0 at %0t", Branch0 & Branch1, $time);
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [14:0] exp);
    @(negedge clk);
    Option   = op;
    Function = fn;
    exp_q.push_back(exp);
  endtask

  task automatic check_edge(input string tag);
    logic [14:0] e;
    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed=%b expected=queued_word (queue empty)", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e)
      else begin
        n_err++;
        $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [14:0] e);
    n_cmp++;
    assert (obs === e)
    else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, e);
    end
  endtask

  initial begin
    // Reset held with lw presented: outputs stay zero across edges.
    Option   = 6'b100011;
    Function = 6'b000000;
    #1 reset = 1'b1;
    #1 check_now("reset_async", W_NOP);
    @(posedge clk); #1 check_now("reset_edge1", W_NOP);
    @(posedge clk); #1 check_now("reset_edge2", W_NOP);
    @(negedge clk);
    reset = 1'b0;
    #1 check_now("release_pre_edge", W_NOP);
    exp_q.push_back(W_LW);
    check_edge("first_after_release_lw");

    // Full instruction sequence, one edge each.
    drive(6'b000000, 6'b100001, W_ADDU); check_edge("addu");
    drive(6'b000000, 6'b100011, W_SUBU); check_edge("subu");
    drive(6'b001101, 6'b000000, W_ORI);  check_edge("ori");
    drive(6'b100011, 6'b000000, W_LW);   check_edge("lw");
    drive(6'b101011, 6'b000000, W_SW);   check_edge("sw");
    drive(6'b000100, 6'b000000, W_BEQ);  check_edge("beq");
    drive(6'b001111, 6'b000000, W_LUI);  check_edge("lui");
    drive(6'b000011, 6'b000000, W_JAL);  check_edge("jal");

    // Async pulse between edges while jal is registered.
    #1 reset = 1'b1;
    #1 check_now("async_drop", W_NOP);
    #1 reset = 1'b0;
    #1 check_now("held_after_pulse", W_NOP);
    exp_q.push_back(W_JAL);
    check_edge("jal_restored");

    // NOP cases and Function-ignored cases.
    drive(6'b000000, 6'b000000, W_NOP);  check_edge("rtype_fn0_nop");
    drive(6'b111111, 6'b000000, W_NOP);  check_edge("op3f_nop");
    drive(6'b000000, 6'b100000, W_NOP);  check_edge("rtype_add_nop");
    drive(6'b000010, 6'b100001, W_NOP);  check_edge("op_j_nop");
    drive(6'b001101, 6'b100011, W_ORI);  check_edge("ori_fn_ignored");
    drive(6'b100011, 6'b100001, W_LW);   check_edge("lw_fn_ignored");
    drive(6'b000100, 6'b111111, W_BEQ);  check_edge("beq_fn_ignored");

    // Reset spanning an edge overrides the pending addu capture.
    @(negedge clk);
    Option   = 6'b000000;
    Function = 6'b100001;
    reset    = 1'b1;
    @(posedge clk); #1 check_now("override_capture", W_NOP);
    @(negedge clk);
    reset = 1'b0;
    Option   = 6'b000000;
    Function = 6'b100011;
    exp_q.push_back(W_SUBU);
    check_edge("first_word_after_override");

    drive(6'b101011, 6'b000000, W_SW);   check_edge("sw_tail");
    drive(6'b000011, 6'b000000, W_JAL);  check_edge("jal_tail");

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
